ifu: RTL and testbench

Instruction fetch unit for the npc core: owns the fetch PC, issues one instruction read at a time to instruction memory over a valid/ready request and valid response channel, and hands each fetched word with its PC to the decode/execute stage over a valid/ready handshake. It sits directly upstream of the single-cycle decode/ALU/register-file datapath, replacing its direct per-cycle memory read. Control-flow changes (jal, jalr, branches) arrive as a one-cycle redirect from the execute stage.

---
 rtl/ifu.sv | 133 +++++++++++++
 tb/tb_ifu.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu.sv
// Instruction fetch unit: owns the fetch PC, keeps one instruction-memory read in flight and hands words to decode.
// Optional ebreak halt is enabled with `define IFU_EBREAK_HALT_EN.
module ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        halted,
    output logic [1:0]  fsm_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // the source keeps valid and payload stable until then, except when a redirect discards it.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2,
        HALT = 2'd3
    } state_t;

    localparam logic [31:0] EBREAK = 32'h0010_0073;

    state_t      state;
    logic [31:0] fetch_pc;
    logic [31:0] req_pc;
    logic        drop;
    logic [31:0] redirect_target;
    logic        req_fire;
    logic        inst_fire;
    logic        halt_now;

    assign redirect_target = redirect_pc & 32'hFFFF_FFFC;
    assign req_fire        = imem_req_valid && imem_req_ready;
    assign inst_fire       = inst_valid && inst_ready;

    assign imem_req_valid = (state == IDLE) && !rst;
    assign imem_req_addr  = fetch_pc;
    assign inst_valid     = (state == HOLD) && !rst;
    assign fsm_state      = state;

`ifdef IFU_EBREAK_HALT_EN
    logic halted_q;
    assign halt_now = (inst == EBREAK);
    assign halted   = halted_q;
`else
    assign halt_now = 1'b0;
    assign halted   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            req_pc   <= RESET_PC;
            drop     <= 1'b0;
            inst     <= 32'h0;
            inst_pc  <= 32'h0;
`ifdef IFU_EBREAK_HALT_EN
            halted_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    // A request accepted in a redirect cycle already carries the stale PC.
                    if (req_fire) begin
                        req_pc <= fetch_pc;
                        drop   <= redirect_valid;
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (redirect_valid) begin
                        if (imem_resp_valid) begin
                            drop  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            drop <= 1'b1;
                        end
                    end else if (imem_resp_valid) begin
                        if (drop) begin
                            drop  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            inst     <= imem_resp_data;
                            inst_pc  <= req_pc;
                            fetch_pc <= req_pc + 32'd4;
                            state    <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (redirect_valid) begin
                        state <= IDLE;
                    end else if (inst_fire) begin
                        if (halt_now) begin
                            state <= HALT;
`ifdef IFU_EBREAK_HALT_EN
                            halted_q <= 1'b1;
`endif
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                HALT: begin
                    if (redirect_valid) begin
                        state <= IDLE;
`ifdef IFU_EBREAK_HALT_EN
                        halted_q <= 1'b0;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
            // Redirect wins over any PC update made above in the same cycle.
            if (redirect_valid) begin
                fetch_pc <= redirect_target;
            end
        end
    end

endmodule

// File: tb/tb_ifu.sv
// Bench for ifu: randomized memory/decode/redirect stimulus against a transaction-level PC model.
// Optional ebreak behaviour follows `define IFU_EBREAK_HALT_EN.
module tb_ifu;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] EBREAK   = 32'h0010_0073;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halted;
  logic [1:0]  fsm_state;

  ifu #(.RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halted         (halted),
    .fsm_state      (fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // scoreboard / model state
  logic [31:0] exp_q[$];
  logic [31:0] exp_pc = RESET_PC;
  logic        halted_exp = 1'b0;
  int          delivered = 0;
  int          since_rst = 0;
  int          next_hs_cyc = 0;
  bit          timing_chk = 0;
  bit          rst_prev = 0;

  // memory model
  bit          pending = 0;
  int          cnt = 0;
  logic [31:0] pend_addr = 32'h0;
  bit          ebreak_en = 0;

  // stimulus knobs
  int          delay_mode = 0;
  bit          ready_rand = 0;
  bit          inst_rdy_rand = 0;
  bit          rand_redirect = 0;
  int          stall_req_n = 0;
  int          stall_inst_n = 0;
  bit          rd_hold_req = 0;
  bit          rd_wait_req = 0;
  bit          rd_wait_resp_req = 0;
  bit          rd_any_req = 0;
  logic [31:0] rd_target = 32'h0;

  // stability tracking
  bit          prev_req_stall = 0;
  logic [31:0] prev_req_addr = 32'h0;
  bit          prev_inst_stall = 0;
  logic [31:0] prev_inst = 32'h0;
  logic [31:0] prev_inst_pc = 32'h0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, expv, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (ebreak_en && a == 32'h8000_000C) return EBREAK;
    return {a[29:0], 2'b10} ^ 32'hA500_0000;
  endfunction

  function automatic int pick_delay();
    if (delay_mode == 0) return 1;
    if (delay_mode == 1) return 3;
    return int'($urandom_range(1, 3));
  endfunction

  function automatic logic [31:0] pick_target();
    logic [31:0] tbl [6];
    tbl[0] = 32'h8000_0000; tbl[1] = 32'h8000_0102; tbl[2] = 32'hFFFF_FFFC;
    tbl[3] = 32'hFFFF_FFF8; tbl[4] = 32'h0000_0013; tbl[5] = $urandom;
    return tbl[$urandom_range(0, 5)];
  endfunction

  // Checks at the falling edge, then advances the model with this cycle's events.
  task automatic observe();
    bit req_hs;
    bit inst_hs;
    if (rst) begin
      chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
      chk("rst_inst_valid", 32'(inst_valid), 32'd0);
      chk("rst_halted", 32'(halted), 32'd0);
      if (rst_prev) begin
        chk("rst_inst", inst, 32'd0);
        chk("rst_inst_pc", inst_pc, 32'd0);
      end
      pending = 0;
      exp_pc = RESET_PC;
      halted_exp = 0;
      since_rst = 0;
      prev_req_stall = 0;
      prev_inst_stall = 0;
      rst_prev = 1;
      return;
    end
    rst_prev = 0;
    chk("halted", 32'(halted), 32'(halted_exp));
    if (halted_exp) chk("halt_quiet", 32'({imem_req_valid, inst_valid}), 32'd0);
    if (prev_req_stall) begin
      chk("req_hold_valid", 32'(imem_req_valid), 32'd1);
      chk("req_hold_addr", imem_req_addr, prev_req_addr);
    end
    if (prev_inst_stall) begin
      chk("inst_hold_valid", 32'(inst_valid), 32'd1);
      chk("inst_hold_word", inst, prev_inst);
      chk("inst_hold_pc", inst_pc, prev_inst_pc);
    end
    req_hs  = imem_req_valid && imem_req_ready;
    inst_hs = inst_valid && inst_ready;
    if (imem_resp_valid) pending = 0;
    if (req_hs) begin
      chk("one_outstanding", 32'(pending), 32'd0);
      chk(exp_pc == 32'h0 ? "wrap_req_addr" : "req_addr", imem_req_addr, exp_pc);
      pending = 1;
      pend_addr = imem_req_addr;
      cnt = pick_delay() - 1;
    end
    if (inst_hs && !redirect_valid) begin
      chk("inst_pc", inst_pc, exp_pc);
      chk("inst", inst, mem_word(exp_pc));
      if (timing_chk && exp_q.size() > 0) begin
        chk("seq_pc", inst_pc, exp_q.pop_front());
        chk("seq_cycle", 32'(since_rst), 32'(next_hs_cyc));
        next_hs_cyc += 3;
      end
      delivered++;
`ifdef IFU_EBREAK_HALT_EN
      if (mem_word(exp_pc) == EBREAK) halted_exp = 1;
`endif
      exp_pc = exp_pc + 32'd4;
    end
    if (redirect_valid) begin
      exp_pc = {redirect_pc[31:2], 2'b00};
      halted_exp = 0;
    end
    prev_req_stall  = imem_req_valid && !imem_req_ready && !redirect_valid;
    prev_req_addr   = imem_req_addr;
    prev_inst_stall = inst_valid && !inst_ready && !redirect_valid;
    prev_inst       = inst;
    prev_inst_pc    = inst_pc;
    since_rst++;
  endtask

  // driver: sets inputs for the cycle just started
  task automatic drive();
    redirect_valid = 0;
    redirect_pc = $urandom;
    if (rst) begin
      imem_req_ready = 0;
      imem_resp_valid = 0;
      imem_resp_data = $urandom;
      inst_ready = 0;
      return;
    end
    imem_req_ready = ready_rand ? ($urandom_range(0, 99) < 70) : 1'b1;
    if (stall_req_n > 0 && imem_req_valid) begin
      imem_req_ready = 0;
      stall_req_n--;
    end
    imem_resp_valid = 0;
    imem_resp_data = $urandom;
    if (pending) begin
      if (cnt == 0) begin
        imem_resp_valid = 1;
        imem_resp_data = mem_word(pend_addr);
      end else begin
        cnt--;
      end
    end
    inst_ready = inst_rdy_rand ? ($urandom_range(0, 99) < 60) : 1'b1;
    if (stall_inst_n > 0 && inst_valid) begin
      inst_ready = 0;
      stall_inst_n--;
    end
    if (rd_hold_req && inst_valid) begin
      redirect_valid = 1; redirect_pc = rd_target; inst_ready = 1; rd_hold_req = 0;
    end else if (rd_wait_req && pending && !imem_resp_valid) begin
      redirect_valid = 1; redirect_pc = rd_target; rd_wait_req = 0;
    end else if (rd_wait_resp_req && imem_resp_valid) begin
      redirect_valid = 1; redirect_pc = rd_target; rd_wait_resp_req = 0;
    end else if (rd_any_req) begin
      redirect_valid = 1; redirect_pc = rd_target; rd_any_req = 0;
    end else if (rand_redirect && $urandom_range(0, 99) < 5) begin
      redirect_valid = 1; redirect_pc = pick_target();
    end
  endtask

  task automatic step();
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic do_reset(input int n);
    rst = 1;
    repeat (n) step();
    rst = 0;
    drive();
  endtask

  initial begin
    rst = 1;
    imem_req_ready = 0; imem_resp_valid = 0; imem_resp_data = 0;
    inst_ready = 0; redirect_valid = 0; redirect_pc = 0;

    // zero-wait memory, one instruction every third cycle from RESET_PC
    do_reset(3);
    exp_q.push_back(32'h8000_0000);
    exp_q.push_back(32'h8000_0004);
    exp_q.push_back(32'h8000_0008);
    next_hs_cyc = 2;
    timing_chk = 1;
    repeat (12) step();
    chk("seq_done", 32'(exp_q.size()), 32'd0);
    timing_chk = 0;

    // back-pressure on both channels
    stall_req_n = 4;
    stall_inst_n = 3;
    repeat (30) step();
    chk("stall_req_used", 32'(stall_req_n), 32'd0);
    chk("stall_inst_used", 32'(stall_inst_n), 32'd0);

    // redirect while waiting, with and without a same-cycle response
    delay_mode = 1;
    rd_target = 32'h8000_0102; rd_wait_req = 1;
    repeat (20) step();
    chk("rd_wait_fired", 32'(rd_wait_req), 32'd0);
    rd_target = 32'h8000_0041; rd_wait_resp_req = 1;
    repeat (20) step();
    chk("rd_wait_resp_fired", 32'(rd_wait_resp_req), 32'd0);

    // redirect in HOLD with inst_ready high, then wrap-around fetch
    delay_mode = 0;
    rd_target = 32'h8000_0200; rd_hold_req = 1;
    repeat (20) step();
    chk("rd_hold_fired", 32'(rd_hold_req), 32'd0);
    rd_target = 32'hFFFF_FFFC; rd_any_req = 1;
    repeat (20) step();

    // ebreak at 8000000C
    ebreak_en = 1;
    do_reset(2);
    repeat (30) step();
`ifdef IFU_EBREAK_HALT_EN
    chk("halted_after_ebreak", 32'(halted), 32'd1);
    rd_target = 32'h8000_0000; rd_any_req = 1;
    repeat (8) step();
    chk("halted_cleared", 32'(halted), 32'd0);
`else
    chk("no_halt", 32'(halted), 32'd0);
    chk("past_ebreak", 32'(exp_pc > 32'h8000_0010), 32'd1);
`endif
    ebreak_en = 0;

    // randomized traffic with a mid-run reset
    do_reset(2);
    ready_rand = 1; inst_rdy_rand = 1; delay_mode = 2; rand_redirect = 1;
    repeat (1500) step();
    do_reset(2);
    repeat (1500) step();
    chk("liveness", 32'(delivered > 200), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
